// File: rtl/pam4_symbol_slicer_pkg.sv
// pam4_pkg: shared constants and types for the 4-PAM receive-side symbol slicer.
// Contents: symbol codes (same encoding as the mapper feeding the FIR),
// FSM state type, default oversampling ratio, sample magnitude helper.
package pam4_pkg;

  localparam logic [2:0] PAM4_P3 = 3'b011;
  localparam logic [2:0] PAM4_P1 = 3'b001;
  localparam logic [2:0] PAM4_M1 = 3'b111;
  localparam logic [2:0] PAM4_M3 = 3'b101;

  localparam int unsigned PAM4_OSR_DEFAULT = 3;
  localparam int unsigned PAM4_SAMPLE_W    = 16;
  localparam int unsigned PAM4_MAG_W       = 17;
  localparam int unsigned PAM4_ERR_W       = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } pam4State_e;

  // |x| of a 16-bit signed sample; 17 bits so that |-32768| = 32768 fits
  function automatic logic [PAM4_MAG_W-1:0] pam4Mag(input logic signed [PAM4_SAMPLE_W-1:0] x);
    logic signed [PAM4_MAG_W-1:0] xExt;
    xExt = PAM4_MAG_W'(x);
    return xExt[PAM4_MAG_W-1] ? PAM4_MAG_W'(-xExt) : PAM4_MAG_W'(xExt);
  endfunction

endpackage

// File: rtl/pam4_symbol_slicer_if.sv
// pam4_symbol_slicer_if: sample stream in / symbol stream out of the slicer.
//   iEnSample600k  sample strobe qualifying iFirOut
//   iFirOut        signed FIR output sample
//   oSym/oSymValid decided 3-bit symbol code and its one-clock valid pulse
//   oSliceErr      decision error (only when PAM4_SLICE_ERR_EN is defined)
// master: sample producer / symbol consumer; slave: the slicer.
interface pam4_symbol_slicer_if;
  import pam4_pkg::*;

  logic                             iEnSample600k;
  logic signed [PAM4_SAMPLE_W-1:0]  iFirOut;
  logic [2:0]                       oSym;
  logic                             oSymValid;
`ifdef PAM4_SLICE_ERR_EN
  logic signed [PAM4_ERR_W-1:0]     oSliceErr;
`endif

  modport master (
    output iEnSample600k, iFirOut,
    input  oSym, oSymValid
`ifdef PAM4_SLICE_ERR_EN
    , input oSliceErr
`endif
  );

  modport slave (
    input  iEnSample600k, iFirOut,
    output oSym, oSymValid
`ifdef PAM4_SLICE_ERR_EN
    , output oSliceErr
`endif
  );

endinterface

// File: rtl/pam4_symbol_slicer_decide.sv
// pam4_decide: combinational 4-level decision of one sample against threshold T.
//   x           signed sample
//   thresh      unsigned outer threshold T
//   symCode_c   decided code (+3/+1/-1/-3)
//   sliceErr_c  x minus ideal level of the decided symbol (PAM4_SLICE_ERR_EN only)
module pam4_decide
  import pam4_pkg::*;
(
  input  logic signed [PAM4_SAMPLE_W-1:0] x,
  input  logic        [PAM4_SAMPLE_W-1:0] thresh,
  output logic        [2:0]               symCode_c
`ifdef PAM4_SLICE_ERR_EN
  , output logic signed [PAM4_ERR_W-1:0]  sliceErr_c
`endif
);

  logic signed [PAM4_ERR_W-1:0] xExt;
  logic signed [PAM4_ERR_W-1:0] tPos;
  logic signed [PAM4_ERR_W-1:0] tNeg;

  // 18-bit signed domain so that -T and the +/-3T/2 levels never overflow
  assign xExt = PAM4_ERR_W'(x);
  assign tPos = $signed({2'b00, thresh});
  assign tNeg = -tPos;

  // Decision regions; with T=0 the two middle regions vanish
  always_comb begin
    symCode_c = PAM4_M3;
    if (xExt >= tPos) begin
      symCode_c = PAM4_P3;
    end else if (xExt >= 18'sd0) begin
      symCode_c = PAM4_P1;
    end else if (xExt >= tNeg) begin
      symCode_c = PAM4_M1;
    end
  end

`ifdef PAM4_SLICE_ERR_EN
  logic [PAM4_MAG_W-1:0]        lvlInner;
  logic [PAM4_MAG_W-1:0]        lvlOuter;
  logic signed [PAM4_ERR_W-1:0] lvlIdeal;

  assign lvlInner = PAM4_MAG_W'(thresh >> 1);
  assign lvlOuter = PAM4_MAG_W'(thresh) + PAM4_MAG_W'(thresh >> 1);

  // Ideal level of the decided symbol, then residual
  always_comb begin
    lvlIdeal = -$signed({1'b0, lvlOuter});
    case (symCode_c)
      PAM4_P3: lvlIdeal =  $signed({1'b0, lvlOuter});
      PAM4_P1: lvlIdeal =  $signed({1'b0, lvlInner});
      PAM4_M1: lvlIdeal = -$signed({1'b0, lvlInner});
      default: lvlIdeal = -$signed({1'b0, lvlOuter});
    endcase
    sliceErr_c = xExt - lvlIdeal;
  end
`endif

endmodule

// File: rtl/pam4_symbol_slicer.sv
// pam4_symbol_slicer: decimates 3x oversampled FIR output to symbol rate.
// Acquires the sampling phase with the largest accumulated |x| over ACQ_SYMS
// symbols, then slices one sample per symbol into the 4-PAM code.
//   iClk12M    12 MHz clock
//   iRst       synchronous reset, active-high
//   bus        sample strobe/data in, symbol/valid (and slice error) out
//   iThresh    outer decision threshold T (unsigned)
//   iAcqStart  pulse: start or restart acquisition
//   oLocked    high while tracking
//   oPhase     selected sampling phase
// Optional: define PAM4_SLICE_ERR_EN to add bus.oSliceErr.
module pam4_symbol_slicer
  import pam4_pkg::*;
#(
  parameter int unsigned OSR      = PAM4_OSR_DEFAULT,
  parameter int unsigned ACQ_SYMS = 16
) (
  input  logic                      iClk12M,
  input  logic                      iRst,
  pam4_symbol_slicer_if.slave       bus,
  input  logic [PAM4_SAMPLE_W-1:0]  iThresh,
  input  logic                      iAcqStart,
  output logic                      oLocked,
  output logic [1:0]                oPhase
);

  localparam int unsigned PH_W  = 2;
  localparam int unsigned SYM_W = $clog2(ACQ_SYMS);
  localparam int unsigned ACC_W = PAM4_MAG_W + $clog2(ACQ_SYMS);

  pam4State_e        state, stateNext;
  logic [PH_W-1:0]   ph, phNext, phInc;
  logic              phWrap;
  logic [SYM_W-1:0]  symCnt, symCntNext;
  logic [ACC_W-1:0]  acc     [OSR];
  logic [ACC_W-1:0]  accNext [OSR];
  logic [ACC_W-1:0]  accUpd  [OSR];
  logic [PH_W-1:0]   bestPh;
  logic [2:0]        symReg, symNext;
  logic              symValidReg, symValidNext;
  logic              lockedReg, lockedNext;
  logic [PH_W-1:0]   phaseReg, phaseNext;
  logic [PAM4_MAG_W-1:0] sampleMag;
  logic [2:0]        symCode_c;

`ifdef PAM4_SLICE_ERR_EN
  logic signed [PAM4_ERR_W-1:0] errReg, errNext, sliceErr_c;
`endif

  pam4_decide uDecide (
    .x         (bus.iFirOut),
    .thresh    (iThresh),
    .symCode_c (symCode_c)
`ifdef PAM4_SLICE_ERR_EN
    , .sliceErr_c(sliceErr_c)
`endif
  );

  assign sampleMag = pam4Mag(bus.iFirOut);
  assign phWrap    = (ph == PH_W'(OSR - 1));
  assign phInc     = phWrap ? '0 : PH_W'(ph + 2'd1);

  // Accumulators as they would be after adding the current sample's magnitude
  always_comb begin
    for (int i = 0; i < OSR; i++) begin
      accUpd[i] = (ph == PH_W'(i)) ? ACC_W'(acc[i] + ACC_W'(sampleMag)) : acc[i];
    end
  end

  // Argmax over the updated accumulators; strict compare keeps the lowest index on ties
  always_comb begin
    bestPh = '0;
    for (int i = 1; i < OSR; i++) begin
      if (accUpd[i] > accUpd[bestPh]) begin
        bestPh = PH_W'(i);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    stateNext    = state;
    phNext       = ph;
    symCntNext   = symCnt;
    accNext      = acc;
    symNext      = symReg;
    symValidNext = 1'b0;
    lockedNext   = lockedReg;
    phaseNext    = phaseReg;
`ifdef PAM4_SLICE_ERR_EN
    errNext      = errReg;
`endif

    if (iAcqStart) begin
      // Restart wins over a coincident strobe; that sample is dropped
      stateNext  = ACQUIRE;
      phNext     = '0;
      symCntNext = '0;
      lockedNext = 1'b0;
      for (int i = 0; i < OSR; i++) begin
        accNext[i] = '0;
      end
    end else begin
      case (state)
        ACQUIRE: begin
          if (bus.iEnSample600k) begin
            accNext = accUpd;
            phNext  = phInc;
            if (phWrap) begin
              symCntNext = SYM_W'(symCnt + 1'b1);
              if (symCnt == SYM_W'(ACQ_SYMS - 1)) begin
                stateNext  = TRACK;
                lockedNext = 1'b1;
                phaseNext  = bestPh;
              end
            end
          end
        end
        TRACK: begin
          if (bus.iEnSample600k) begin
            phNext = phInc;
            if (ph == phaseReg) begin
              symNext      = symCode_c;
              symValidNext = 1'b1;
`ifdef PAM4_SLICE_ERR_EN
              errNext      = sliceErr_c;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state       <= IDLE;
      ph          <= '0;
      symCnt      <= '0;
      symReg      <= '0;
      symValidReg <= 1'b0;
      lockedReg   <= 1'b0;
      phaseReg    <= '0;
      for (int i = 0; i < OSR; i++) begin
        acc[i] <= '0;
      end
`ifdef PAM4_SLICE_ERR_EN
      errReg      <= '0;
`endif
    end else begin
      state       <= stateNext;
      ph          <= phNext;
      symCnt      <= symCntNext;
      symReg      <= symNext;
      symValidReg <= symValidNext;
      lockedReg   <= lockedNext;
      phaseReg    <= phaseNext;
      for (int i = 0; i < OSR; i++) begin
        acc[i] <= accNext[i];
      end
`ifdef PAM4_SLICE_ERR_EN
      errReg      <= errNext;
`endif
    end
  end

  assign bus.oSym       = symReg;
  assign bus.oSymValid  = symValidReg;
  assign oLocked        = lockedReg;
  assign oPhase         = phaseReg;
`ifdef PAM4_SLICE_ERR_EN
  assign bus.oSliceErr  = errReg;
`endif

endmodule

// File: tb/tb_pam4_symbol_slicer.sv
// tb_pam4_symbol_slicer: directed scoreboard bench for pam4_symbol_slicer.
// Stimulus pushes expected symbols into a queue; a monitor pops on every
// oSymValid, so any unexpected valid pulse is also reported.
module tb_pam4_symbol_slicer;
  import pam4_pkg::*;

  typedef struct {
    logic [2:0] sym;
    int         err;
  } expSym_t;

  logic        iClk12M = 1'b0;
  logic        iRst;
  logic [15:0] iThresh;
  logic        iAcqStart;
  logic        oLocked;
  logic [1:0]  oPhase;

  pam4_symbol_slicer_if bus ();

  pam4_symbol_slicer dut (
    .iClk12M   (iClk12M),
    .iRst      (iRst),
    .bus       (bus),
    .iThresh   (iThresh),
    .iAcqStart (iAcqStart),
    .oLocked   (oLocked),
    .oPhase    (oPhase)
  );

  always #5 iClk12M = ~iClk12M;

  expSym_t expQ[$];
  int      checks = 0;
  int      errors = 0;

  task automatic checkVal(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One strobe followed by one idle clock; optionally expects a symbol out
  task automatic strobe(input int x, input bit expOut, input logic [2:0] sym, input int err);
    if (expOut) expQ.push_back('{sym: sym, err: err});
    bus.iEnSample600k = 1'b1;
    bus.iFirOut       = 16'(x);
    @(posedge iClk12M); #1;
    bus.iEnSample600k = 1'b0;
    @(posedge iClk12M); #1;
  endtask

  // Strobes on phases 0,1,2 with only the phase-1 sample expected to be sliced
  task automatic sliceP1(input int x, input logic [2:0] sym, input int err);
    strobe(0, 1'b0, 3'b000, 0);
    strobe(x, 1'b1, sym, err);
    strobe(0, 1'b0, 3'b000, 0);
  endtask

  task automatic acqPulse();
    iAcqStart = 1'b1;
    @(posedge iClk12M); #1;
    iAcqStart = 1'b0;
  endtask

  // 48 acquisition strobes of a repeating 3-sample pattern
  task automatic runAcq(input int p0, input int p1, input int p2, input int expPhase, input string tag);
    int pat [3];
    pat[0] = p0; pat[1] = p1; pat[2] = p2;
    for (int k = 0; k < 48; k++) begin
      if (k == 47) checkVal({tag, "_locked_before_last"}, int'(oLocked), 0);
      strobe(pat[k % 3], 1'b0, 3'b000, 0);
    end
    checkVal({tag, "_locked"}, int'(oLocked), 1);
    checkVal({tag, "_phase"}, int'(oPhase), expPhase);
  endtask

  // Monitor: every valid pulse must match the head of the expectation queue
  initial begin
    expSym_t e;
    forever begin
      @(negedge iClk12M);
      if (bus.oSymValid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: oSym=%b with no symbol expected", bus.oSym);
        end else begin
          e = expQ.pop_front();
          if (bus.oSym !== e.sym) begin
            errors++;
            $display("FAIL sym: got %b, expected %b", bus.oSym, e.sym);
          end
`ifdef PAM4_SLICE_ERR_EN
          checks++;
          if (int'(bus.oSliceErr) != e.err) begin
            errors++;
            $display("FAIL slice_err: got %0d, expected %0d", int'(bus.oSliceErr), e.err);
          end
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accM [3];
    int pat  [3];
    int bestM;

    iRst              = 1'b1;
    iAcqStart         = 1'b0;
    iThresh           = 16'd1000;
    bus.iEnSample600k = 1'b0;
    bus.iFirOut       = '0;

    // Reset held for 5 clocks with strobes toggling
    for (int i = 0; i < 5; i++) begin
      @(posedge iClk12M); #1;
      bus.iEnSample600k = ~bus.iEnSample600k;
      bus.iFirOut       = 16'(i * 700);
    end
    iRst              = 1'b0;
    bus.iEnSample600k = 1'b0;
    @(posedge iClk12M); #1;
    checkVal("rst_sym",    int'(bus.oSym), 0);
    checkVal("rst_valid",  int'(bus.oSymValid), 0);
    checkVal("rst_locked", int'(oLocked), 0);
    checkVal("rst_phase",  int'(oPhase), 0);

    // Strobes in IDLE are ignored
    strobe(20000, 1'b0, 3'b000, 0);
    strobe(-20000, 1'b0, 3'b000, 0);
    checkVal("idle_locked", int'(oLocked), 0);

    // Acquisition: acc = [1600, 28800, 800] -> phase 1
    acqPulse();
    runAcq(100, 1800, -50, 1, "acq1");

    // Slicing at T=1000; ideal levels +-500, +-1500
    sliceP1(1000,   PAM4_P3,   -500);
    sliceP1(999,    PAM4_P1,    499);
    sliceP1(0,      PAM4_P1,   -500);
    sliceP1(-1,     PAM4_M1,    499);
    sliceP1(-1000,  PAM4_M1,   -500);
    sliceP1(-1001,  PAM4_M3,    499);
    sliceP1(32767,  PAM4_P3,  31267);
    sliceP1(-32768, PAM4_M3, -31268);
    sliceP1(1700,   PAM4_P3,    200);
    sliceP1(-400,   PAM4_M1,    100);

    // T=0 collapses to two regions; all ideal levels are 0
    iThresh = 16'd0;
    sliceP1(0,  PAM4_P3, 0);
    sliceP1(-1, PAM4_M3, -1);
    iThresh = 16'd1000;

    // Restart mid-TRACK, then tie acquisition -> lowest index
    acqPulse();
    checkVal("restart_locked_drop", int'(oLocked), 0);
    runAcq(500, 500, 500, 0, "tie");

    // Restart coincident with a strobe on the tracked phase: sample dropped, no valid
    bus.iEnSample600k = 1'b1;
    bus.iFirOut       = 16'(30000);
    iAcqStart         = 1'b1;
    @(posedge iClk12M); #1;
    bus.iEnSample600k = 1'b0;
    iAcqStart         = 1'b0;
    @(posedge iClk12M); #1;
    checkVal("coinc_locked_drop", int'(oLocked), 0);

    // Expected accumulators exclude the 30000 sample
    pat[0] = 300; pat[1] = -100; pat[2] = 290;
    for (int i = 0; i < 3; i++) accM[i] = 16 * ((pat[i] < 0) ? -pat[i] : pat[i]);
    bestM = 0;
    for (int i = 1; i < 3; i++) if (accM[i] > accM[bestM]) bestM = i;
    runAcq(pat[0], pat[1], pat[2], bestM, "coinc");

    // Tracking on phase 0 after re-lock
    strobe(1700, 1'b1, PAM4_P3, 200);
    strobe(0, 1'b0, 3'b000, 0);
    strobe(0, 1'b0, 3'b000, 0);
    strobe(-2000, 1'b1, PAM4_M3, -500);

    // Bounded drain: anything still queued never appeared
    repeat (4) @(posedge iClk12M);
    #1;
    checkVal("queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
